// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Data memory that sits between the control unit/ALU and the register file.
//   After reset it walks the whole array writing zeros (CLEAR), then serves
//   CPU traffic (IDLE): one registered read and one write per cycle, plus an
//   operand preload that drops both ALU operands into fixed slots on a single
//   edge. The result slot is mirrored, registered, on result_out.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (synchronous release expected)
//   rd_en      read request; rd_addr is the word address
//   rd_data    read data, valid while rd_valid=1, holds last value otherwise
//   rd_valid   one-cycle pulse, one edge after an accepted rd_en
//   wr_en      write request of wr_data to wr_addr
//   op_load    write operand1 -> mem[OP1_ADDR], operand2 -> mem[OP2_ADDR]
//   result_out registered copy of mem[RES_ADDR] (0 while clearing)
//   busy       1 while clearing; every request is ignored then
//   err        sticky error: request dropped or address >= DEPTH
//   dbg_state  FSM state (0 = CLEAR, 1 = IDLE) for checkers

module data_memory_ctrl #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OP1_ADDR   = 9,
  parameter int OP2_ADDR   = 10,
  parameter int RES_ADDR   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  op_load,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  busy,
  output logic                  err,
  output logic                  dbg_state
);

  // Request semantics: rd_en, wr_en and op_load are valid-only requests with
  // no per-request ready. busy=1 is the single "not ready" indication: any
  // request presented while busy is discarded (and flagged on err). When
  // busy=0 every request is accepted in the cycle it is presented.

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] OP1_IDX  = ADDR_WIDTH'(OP1_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OP2_IDX  = ADDR_WIDTH'(OP2_ADDR);
  localparam bit                    OP1_OK   = (OP1_ADDR < DEPTH);
  localparam bit                    OP2_OK   = (OP2_ADDR < DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   res_word;

  logic clr_we, op_we, cpu_we, rd_go, err_set;

  // A result slot outside the array simply reads as zero.
  if (RES_ADDR < DEPTH) begin : g_res
    assign res_word = mem_q[RES_ADDR];
  end else begin : g_nores
    assign res_word = '0;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (ptr_q == LAST_PTR) state_d = ST_IDLE;
      ST_IDLE:  state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // FSM: outputs / strobes
  always_comb begin
    busy    = 1'b0;
    clr_we  = 1'b0;
    op_we   = 1'b0;
    cpu_we  = 1'b0;
    rd_go   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        err_set = rd_en | wr_en | op_load;
      end
      ST_IDLE: begin
        op_we   = op_load;
        // op_load owns the write port; a concurrent CPU write loses.
        cpu_we  = wr_en & ~op_load & in_range(wr_addr);
        rd_go   = rd_en;
        err_set = (wr_en & (op_load | ~in_range(wr_addr)))
                | (rd_en & ~in_range(rd_addr));
      end
      default: ;
    endcase
  end

  // Datapath next-state. Reads use the pre-edge array contents, which gives
  // read-first behaviour when a read and a write hit the same word.
  always_comb begin
    ptr_d      = (state_q == ST_CLEAR) ? ptr_q + 1'b1 : ptr_q;
    rd_valid_d = rd_go;
    rd_data_d  = rd_data_q;
    if (rd_go) rd_data_d = in_range(rd_addr) ? mem_q[rd_addr] : '0;
    result_d   = (state_q == ST_CLEAR) ? '0 : res_word;
    err_d      = err_q | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  // Storage has no reset; CLEAR defines its contents.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[ptr_q] <= '0;
    if (op_we) begin
      if (OP1_OK) mem_q[OP1_IDX] <= operand1;
      if (OP2_OK) mem_q[OP2_IDX] <= operand2;
    end
    if (cpu_we) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign result_out = result_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule
